// File: rtl/key_pkg.sv
// Shared constants and helpers for the two-channel push-button conditioner.
// Keys are active-low: KEY_IDLE is the released level.
package key_pkg;

  localparam logic       KEY_IDLE         = 1'b1;
  localparam int         DEBOUNCE_DEFAULT = 1000000;
  localparam int         CNT_W_DEFAULT    = 20;
  localparam logic [1:0] EN_RESET_DEFAULT = 2'b01;

  // A press is an accepted transition from the idle level to the active level.
  function automatic logic isPress(input logic prevLevel, input logic curLevel);
    return (prevLevel == KEY_IDLE) && (curLevel != KEY_IDLE);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level,
// registered press pulse and a press-toggled enable flop.
module debounce_chan
  import key_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int   CNT_W           = CNT_W_DEFAULT,
  parameter logic EN_INIT         = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic en
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stablePrev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;
  logic             en_q;
  logic             en_d;

  // Any return to the stable value restarts the count; acceptance clears it.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = isPress(stablePrev_q, stable_q);
    en_d    = en_q ^ press_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= KEY_IDLE;
      sync2_q      <= KEY_IDLE;
      stable_q     <= KEY_IDLE;
      stablePrev_q <= KEY_IDLE;
      cnt_q        <= '0;
      press_q      <= 1'b0;
      en_q         <= EN_INIT;
    end else begin
      sync1_q      <= key_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stablePrev_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
      en_q         <= en_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;
  assign en    = en_q;

endmodule

// File: rtl/key_debounce2.sv
// Two independent debounced buttons driving the scan encoder enables,
// plus per-key press pulses and debounced levels.
module key_debounce2
  import key_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int         CNT_W           = CNT_W_DEFAULT,
  parameter logic [1:0] EN_RESET        = EN_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_in,
  output logic       EN_in1,
  output logic       EN_in0,
  output logic [1:0] key_press,
  output logic [1:0] key_level
);

  debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .EN_INIT         (EN_RESET[1])
  ) u_chan1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_in[1]),
    .level   (key_level[1]),
    .press   (key_press[1]),
    .en      (EN_in1)
  );

  debounce_chan #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .EN_INIT         (EN_RESET[0])
  ) u_chan0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (key_in[0]),
    .level   (key_level[0]),
    .press   (key_press[0]),
    .en      (EN_in0)
  );

endmodule

// File: tb/tb_key_debounce2.sv
// Directed bench for key_debounce2 with an 8-cycle debounce window.
// Observed vector is {EN_in1, EN_in0, key_press[1:0], key_level[1:0]}.
module tb_key_debounce2;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_in;
  logic       EN_in1;
  logic       EN_in0;
  logic [1:0] key_press;
  logic [1:0] key_level;

  int compared;
  int mismatched;

  key_debounce2 #(
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4),
    .EN_RESET        (2'b01)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .EN_in1    (EN_in1),
    .EN_in0    (EN_in0),
    .key_press (key_press),
    .key_level (key_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expected);
    logic [5:0] observed;
    observed = {EN_in1, EN_in0, key_press, key_level};
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b required %b", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset with both keys already held down.
    rst_n  = 1'b0;
    key_in = 2'b00;
    step(3);
    checkOutput("reset_state", 6'b01_00_11);

    // Release reset: last reset edge is edge 0; level at 10, pulse at 11.
    rst_n = 1'b1;
    step(9);
    checkOutput("post_reset_e9", 6'b01_00_11);
    step(1);
    checkOutput("post_reset_level_e10", 6'b01_00_00);
    step(1);
    checkOutput("post_reset_press_e11", 6'b10_11_00);
    step(1);
    checkOutput("post_reset_pulse_end", 6'b10_00_00);

    // Release both: level returns, no pulse and no toggle.
    key_in = 2'b11;
    step(11);
    checkOutput("release_both", 6'b10_00_11);
    step(1);

    // Clean press of key0 held for 20 cycles.
    key_in = 2'b10;
    step(10);
    checkOutput("key0_level_e10", 6'b10_00_10);
    step(1);
    checkOutput("key0_press_e11", 6'b11_01_10);
    step(1);
    checkOutput("key0_pulse_end", 6'b11_00_10);
    step(8);
    checkOutput("key0_held", 6'b11_00_10);
    key_in = 2'b11;
    step(12);
    checkOutput("key0_release", 6'b11_00_11);

    // Key1 bounce: low 5, high 1, low; final low reaches s2 at edge 8.
    key_in = 2'b01;
    step(5);
    key_in = 2'b11;
    step(1);
    key_in = 2'b01;
    step(9);
    checkOutput("bounce_not_yet_e15", 6'b11_00_11);
    step(1);
    checkOutput("bounce_level_e16", 6'b11_00_01);
    step(1);
    checkOutput("bounce_press_e17", 6'b01_10_01);
    step(1);
    checkOutput("bounce_pulse_end", 6'b01_00_01);
    key_in = 2'b11;
    step(12);
    checkOutput("bounce_release", 6'b01_00_11);

    // Simultaneous press of both keys.
    key_in = 2'b00;
    step(10);
    checkOutput("simul_level_e10", 6'b01_00_00);
    step(1);
    checkOutput("simul_press_e11", 6'b10_11_00);
    step(1);
    checkOutput("simul_pulse_end", 6'b10_00_00);
    key_in = 2'b11;
    step(12);
    checkOutput("simul_release", 6'b10_00_11);

    // Glitch of 7 cycles peaks at count 7 and must not be accepted.
    key_in = 2'b10;
    step(7);
    key_in = 2'b11;
    step(3);
    checkOutput("glitch_e10", 6'b10_00_11);
    step(1);
    checkOutput("glitch_e11", 6'b10_00_11);
    step(3);

    // Reset mid-count on key1: count reaches 5 after edge 7.
    key_in = 2'b01;
    step(7);
    rst_n = 1'b0;
    step(1);
    checkOutput("midcount_reset", 6'b01_00_11);
    rst_n = 1'b1;
    step(9);
    checkOutput("midcount_no_early_e9", 6'b01_00_11);
    step(1);
    checkOutput("midcount_level_e10", 6'b01_00_01);
    step(1);
    checkOutput("midcount_press_e11", 6'b11_10_01);
    step(1);
    checkOutput("midcount_pulse_end", 6'b11_00_01);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
